// File: rtl/smc777_kbd_pkg.sv
// smc777_kbd_pkg
// Shared definitions for the SMC-777 keyboard front end:
//   - set-2 scancodes of the keys that are consumed as modifier state
//   - key_evt_t, the field layout of the hps_io ps2_key event word
//   - is_modifier(), which decides if an event updates state instead of the FIFO
package smc777_kbd_pkg;

   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_ENTER  = 8'h5A;

   // Bit layout matches ps2_key[10:0] so the raw word casts directly.
   typedef struct packed {
      logic       tog;
      logic       make;
      logic       ext;
      logic [7:0] code;
   } key_evt_t;

   // E0 12 is the fake shift around PrtSc, so only the plain shift codes count.
   // Ctrl and caps are recognised with or without the E0 prefix.
   function automatic logic is_modifier(input logic ext, input logic [7:0] code);
      return (!ext && (code == SC_LSHIFT || code == SC_RSHIFT)) ||
             (code == SC_CTRL) || (code == SC_CAPS);
   endfunction

endpackage

// File: rtl/smc777_keymap.sv
// smc777_keymap
// Synchronous keymap ROM, one-cycle read latency.
//   clk  in  : system clock
//   addr in  : {ext, shift, set-2 scancode}
//   data out : SMC-777 ASCII code, 0x00 for unmapped keys
// Holds the unshifted and shifted tables for the main block plus a small
// extended (E0) table; extended keys ignore shift.
module smc777_keymap
   import smc777_kbd_pkg::*;
(
   input  logic       clk,
   input  logic [9:0] addr,
   output logic [7:0] data
);

   // Returns {shifted, unshifted} for a non-extended scancode.
   function automatic logic [15:0] main_pair(input logic [7:0] code);
      logic [15:0] p;
      p = 16'h0000;
      case (code)
         8'h1C: p = {8'h41, 8'h61};  8'h32: p = {8'h42, 8'h62};
         8'h21: p = {8'h43, 8'h63};  8'h23: p = {8'h44, 8'h64};
         8'h24: p = {8'h45, 8'h65};  8'h2B: p = {8'h46, 8'h66};
         8'h34: p = {8'h47, 8'h67};  8'h33: p = {8'h48, 8'h68};
         8'h43: p = {8'h49, 8'h69};  8'h3B: p = {8'h4A, 8'h6A};
         8'h42: p = {8'h4B, 8'h6B};  8'h4B: p = {8'h4C, 8'h6C};
         8'h3A: p = {8'h4D, 8'h6D};  8'h31: p = {8'h4E, 8'h6E};
         8'h44: p = {8'h4F, 8'h6F};  8'h4D: p = {8'h50, 8'h70};
         8'h15: p = {8'h51, 8'h71};  8'h2D: p = {8'h52, 8'h72};
         8'h1B: p = {8'h53, 8'h73};  8'h2C: p = {8'h54, 8'h74};
         8'h3C: p = {8'h55, 8'h75};  8'h2A: p = {8'h56, 8'h76};
         8'h1D: p = {8'h57, 8'h77};  8'h22: p = {8'h58, 8'h78};
         8'h35: p = {8'h59, 8'h79};  8'h1A: p = {8'h5A, 8'h7A};
         8'h16: p = {8'h21, 8'h31};  8'h1E: p = {8'h40, 8'h32};
         8'h26: p = {8'h23, 8'h33};  8'h25: p = {8'h24, 8'h34};
         8'h2E: p = {8'h25, 8'h35};  8'h36: p = {8'h5E, 8'h36};
         8'h3D: p = {8'h26, 8'h37};  8'h3E: p = {8'h2A, 8'h38};
         8'h46: p = {8'h28, 8'h39};  8'h45: p = {8'h29, 8'h30};
         8'h4E: p = {8'h5F, 8'h2D};  8'h55: p = {8'h2B, 8'h3D};
         8'h54: p = {8'h7B, 8'h5B};  8'h5B: p = {8'h7D, 8'h5D};
         8'h5D: p = {8'h7C, 8'h5C};  8'h4C: p = {8'h3A, 8'h3B};
         8'h52: p = {8'h22, 8'h27};  8'h41: p = {8'h3C, 8'h2C};
         8'h49: p = {8'h3E, 8'h2E};  8'h4A: p = {8'h3F, 8'h2F};
         8'h0E: p = {8'h7E, 8'h60};  8'h29: p = {8'h20, 8'h20};
         SC_ENTER: p = {8'h0D, 8'h0D};
         8'h66: p = {8'h08, 8'h08};  8'h0D: p = {8'h09, 8'h09};
         8'h76: p = {8'h1B, 8'h1B};
         default: p = 16'h0000;
      endcase
      return p;
   endfunction

   function automatic logic [7:0] ext_code(input logic [7:0] code);
      logic [7:0] d;
      d = 8'h00;
      case (code)
         SC_ENTER: d = 8'h0D;   // keypad enter
         8'h4A:    d = 8'h2F;   // keypad slash
         8'h71:    d = 8'h7F;   // delete
         default:  d = 8'h00;
      endcase
      return d;
   endfunction

   function automatic logic [7:0] rom_read(input logic [9:0] a);
      logic [15:0] p;
      p = main_pair(a[7:0]);
      if (a[9])
         return ext_code(a[7:0]);
      return a[8] ? p[15:8] : p[7:0];
   endfunction

   always_ff @(posedge clk) begin
      data <= rom_read(addr);
   end

endmodule

// File: rtl/smc777_keyboard.sv
// smc777_keyboard
// Turns hps_io ps2_key events into SMC-777 ASCII codes, tracks shift/ctrl/caps
// and queues codes in a first-word-fall-through FIFO for the CPU port.
//   clk       in  : system clock (clk_sys)
//   reset     in  : asynchronous, active-high
//   ps2_key   in  : [10] toggle, [9] make, [8] E0, [7:0] set-2 scancode
//   kb_rd     in  : pop strobe
//   kb_clr    in  : flush FIFO and clear overflow
//   key_data  out : FIFO head, 0x00 when empty
//   key_valid out : FIFO non-empty
//   key_count out : occupancy
//   overflow  out : sticky, a code was dropped on a full FIFO
//   shift/ctrl/caps out : modifier state
//   kb_irq    out : FIFO-non-empty interrupt, built only when SMC777_KBD_IRQ_EN
//                   is defined, otherwise tied to 0
// Parameter DEPTH: FIFO entries, power of two, 2..64.
module smc777_keyboard
   import smc777_kbd_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [10:0]            ps2_key,
   input  logic                   kb_rd,
   input  logic                   kb_clr,
   output logic [7:0]             key_data,
   output logic                   key_valid,
   output logic [$clog2(DEPTH):0] key_count,
   output logic                   overflow,
   output logic                   shift,
   output logic                   ctrl,
   output logic                   caps,
   output logic                   kb_irq
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   key_evt_t         evt_in;
   logic             armed, prev_tog, evt;
   logic             vld_p0, make_p0, ext_p0;
   logic [7:0]       code_p0;
   logic             lshift, rshift, lctrl, rctrl;
   logic             vld_p1, caps_p1, ctrl_p1;
   logic [7:0]       base_p1, code_p2;
   logic             push_req, pop, push_ok;
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count_nxt;

   // Ctrl wins over caps: masking to 5 bits discards the case bit anyway.
   function automatic logic [7:0] apply_mods(input logic [7:0] c,
                                             input logic       caps_on,
                                             input logic       ctrl_on);
      logic [7:0] r;
      r = c;
      if (caps_on && ((c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A)))
         r = c ^ 8'h20;
      if (ctrl_on && c >= 8'h40 && c <= 8'h7F)
         r = c & 8'h1F;
      return r;
   endfunction

   assign evt_in = ps2_key;
   assign evt    = armed && (evt_in.tog != prev_tog);
   assign shift  = lshift | rshift;
   assign ctrl   = lctrl | rctrl;

   // Stage 0: detect toggle change and capture the event.
   // armed stays low for one clock after reset so a toggle already at 1 is
   // absorbed into prev_tog rather than seen as an event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed    <= 1'b0;
         prev_tog <= 1'b0;
         vld_p0   <= 1'b0;
      end else begin
         armed    <= 1'b1;
         prev_tog <= evt_in.tog;
         vld_p0   <= evt;
      end
   end

   always_ff @(posedge clk) begin
      make_p0 <= evt_in.make;
      ext_p0  <= evt_in.ext;
      code_p0 <= evt_in.code;
   end

   // Stage 1: modifier update and keymap lookup.
   // The lookup and the captured caps/ctrl see modifier state from strictly
   // earlier events, so a modifier followed next cycle by a key applies.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lshift <= 1'b0;
         rshift <= 1'b0;
         lctrl  <= 1'b0;
         rctrl  <= 1'b0;
         caps   <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         if (vld_p0) begin
            if (!ext_p0 && code_p0 == SC_LSHIFT) lshift <= make_p0;
            if (!ext_p0 && code_p0 == SC_RSHIFT) rshift <= make_p0;
            if (code_p0 == SC_CTRL) begin
               if (ext_p0) rctrl <= make_p0;
               else        lctrl <= make_p0;
            end
            if (code_p0 == SC_CAPS && make_p0) caps <= ~caps;
         end
         vld_p1 <= vld_p0 && make_p0 && !is_modifier(ext_p0, code_p0);
      end
   end

   always_ff @(posedge clk) begin
      caps_p1 <= caps;
      ctrl_p1 <= ctrl;
   end

   smc777_keymap u_keymap (
      .clk  (clk),
      .addr ({ext_p0, shift, code_p0}),
      .data (base_p1)
   );

   // Stage 2: transform and FIFO write.
   assign code_p2  = apply_mods(base_p1, caps_p1, ctrl_p1);
   assign push_req = vld_p1 && (code_p2 != 8'h00);
   assign pop      = kb_rd && key_valid;
   assign push_ok  = push_req && ((key_count != CNT_W'(DEPTH)) || pop);

   always_comb begin
      count_nxt = key_count;
      if (kb_clr)
         count_nxt = '0;
      else if (push_ok && !pop)
         count_nxt = key_count + CNT_W'(1);
      else if (pop && !push_ok)
         count_nxt = key_count - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         key_count <= '0;
         overflow  <= 1'b0;
      end else if (kb_clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         key_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_req && !push_ok) overflow <= 1'b1;
         key_count <= count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !kb_clr)
         mem[wr_ptr] <= code_p2;
   end

   assign key_valid = (key_count != '0);
   assign key_data  = key_valid ? mem[rd_ptr] : 8'h00;

`ifdef SMC777_KBD_IRQ_EN
   // Level follows next-cycle occupancy, so it rises with key_valid and drops
   // on the pop that empties the FIFO or on kb_clr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         kb_irq <= 1'b0;
      else
         kb_irq <= (count_nxt != '0);
   end
`else
   assign kb_irq = 1'b0;
`endif

endmodule

// File: tb/tb_smc777_keyboard.sv
module tb_smc777_keyboard;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = '0;
  logic        kb_rd = 1'b0;
  logic        kb_clr = 1'b0;
  logic [7:0]  key_data;
  logic        key_valid;
  logic [3:0]  key_count;
  logic        overflow, shift, ctrl, caps, kb_irq;

  always #5 clk = ~clk;

  smc777_keyboard #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_key   (ps2_key),
    .kb_rd     (kb_rd),
    .kb_clr    (kb_clr),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_count (key_count),
    .overflow  (overflow),
    .shift     (shift),
    .ctrl      (ctrl),
    .caps      (caps),
    .kb_irq    (kb_irq)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit tog     = 1'b0;

  // Reference model state
  byte unsigned mq[$];
  bit m_ovf, m_ls, m_rs, m_lc, m_rc, m_caps;

  string let_s  = "abcdefghijklmnopqrstuvwxyz";
  string dig_s  = "1234567890";
  string dig_sh = "!@#$%^&*()";
  byte unsigned pun_ch[11]  = '{8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F, 8'h60};
  byte unsigned pun_chs[11] = '{8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F, 8'h7E};
  byte unsigned let_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned dig_sc[10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  byte unsigned pun_sc[11] = '{8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h0E};
  byte unsigned spc_sc[5]  = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  byte unsigned spc_ch[5]  = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
  byte unsigned ext_pool[4] = '{8'h5A, 8'h4A, 8'h71, 8'h0E};
  byte unsigned fill_sc[9]  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

  function automatic byte unsigned model_map(bit ex, bit sh, byte unsigned sc);
    if (ex) begin
      if (sc == 8'h5A) return 8'h0D;
      if (sc == 8'h4A) return 8'h2F;
      if (sc == 8'h71) return 8'h7F;
      return 8'h00;
    end
    for (int i = 0; i < 26; i++)
      if (let_sc[i] == sc) return sh ? 8'(let_s[i] - 32) : 8'(let_s[i]);
    for (int i = 0; i < 10; i++)
      if (dig_sc[i] == sc) return sh ? 8'(dig_sh[i]) : 8'(dig_s[i]);
    for (int i = 0; i < 11; i++)
      if (pun_sc[i] == sc) return sh ? pun_chs[i] : pun_ch[i];
    for (int i = 0; i < 5; i++)
      if (spc_sc[i] == sc) return spc_ch[i];
    return 8'h00;
  endfunction

  function automatic void model_event(bit mk, bit ex, byte unsigned sc);
    byte unsigned c;
    if (!ex && sc == 8'h12)      m_ls = mk;
    else if (!ex && sc == 8'h59) m_rs = mk;
    else if (sc == 8'h14) begin
      if (ex) m_rc = mk; else m_lc = mk;
    end else if (sc == 8'h58) begin
      if (mk) m_caps = !m_caps;
    end else if (mk) begin
      c = model_map(ex, m_ls | m_rs, sc);
      if (m_lc | m_rc) begin
        if (c >= 64 && c < 128) c = 8'(c % 32);
      end else if (m_caps) begin
        if (c >= "a" && c <= "z")      c = 8'(c - 32);
        else if (c >= "A" && c <= "Z") c = 8'(c + 32);
      end
      if (c != 0) begin
        if (mq.size() < DEPTH) mq.push_back(c);
        else m_ovf = 1'b1;
      end
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovf = 0; m_ls = 0; m_rs = 0; m_lc = 0; m_rc = 0; m_caps = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    bit ne;
    ne = (mq.size() != 0);
    chk({tag, ".valid"}, 32'(key_valid), 32'(ne));
    chk({tag, ".data"},  32'(key_data),  ne ? 32'(mq[0]) : 32'd0);
    chk({tag, ".count"}, 32'(key_count), 32'(mq.size()));
    chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, ".shift"}, 32'(shift),     32'(m_ls | m_rs));
    chk({tag, ".ctrl"},  32'(ctrl),      32'(m_lc | m_rc));
    chk({tag, ".caps"},  32'(caps),      32'(m_caps));
`ifdef SMC777_KBD_IRQ_EN
    chk({tag, ".irq"},   32'(kb_irq),    32'(ne));
`else
    chk({tag, ".irq"},   32'(kb_irq),    32'd0);
`endif
  endtask

  task automatic send(input bit mk, input bit ex, input byte unsigned sc);
    tog = ~tog;
    ps2_key = {tog, mk, ex, sc};
    tick();
    model_event(mk, ex, sc);
  endtask

  task automatic settle();
    tick();
    tick();
  endtask

  task automatic pop();
    kb_rd = 1'b1;
    tick();
    kb_rd = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clear();
    kb_clr = 1'b1;
    tick();
    kb_clr = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic rand_event();
    int r;
    r = $urandom_range(0, 99);
    if (r < 15) begin
      case ($urandom_range(0, 3))
        0: send(1'($urandom_range(0, 1)), 1'b0, 8'h12);
        1: send(1'($urandom_range(0, 1)), 1'b0, 8'h59);
        2: send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h14);
        default: send(1'($urandom_range(0, 1)), 1'b0, 8'h58);
      endcase
    end else if (r < 25) begin
      send(1'b0, 1'b0, let_sc[$urandom_range(0, 25)]);
    end else if (r < 32) begin
      send(1'b1, 1'b1, ext_pool[$urandom_range(0, 3)]);
    end else if (r < 36) begin
      send(1'b1, 1'b0, 8'h05);
    end else if (r < 70) begin
      send(1'b1, 1'b0, let_sc[$urandom_range(0, 25)]);
    end else if (r < 82) begin
      send(1'b1, 1'b0, dig_sc[$urandom_range(0, 9)]);
    end else if (r < 94) begin
      send(1'b1, 1'b0, pun_sc[$urandom_range(0, 10)]);
    end else begin
      send(1'b1, 1'b0, spc_sc[$urandom_range(0, 4)]);
    end
  endtask

  initial begin
    // Reset state
    model_reset();
    tick();
    check_state("reset");
    reset = 1'b0;
    tick();

    // Plain 'a'
    send(1'b1, 1'b0, 8'h1C);
    tick();
    chk("a_lat1.valid", 32'(key_valid), 32'd0);
    tick();
    chk("a.valid", 32'(key_valid), 32'd1);
    chk("a.data", 32'(key_data), 32'h61);
    check_state("a");
    pop();
    chk("a_pop.valid", 32'(key_valid), 32'd0);

    // Shift make/break, caps
    send(1'b1, 1'b0, 8'h12);
    send(1'b1, 1'b0, 8'h1C);
    settle();
    chk("shift_a", 32'(key_data), 32'h41);
    pop();
    send(1'b0, 1'b0, 8'h12);
    send(1'b1, 1'b0, 8'h1C);
    settle();
    chk("unshift_a", 32'(key_data), 32'h61);
    pop();
    send(1'b1, 1'b0, 8'h58);
    send(1'b0, 1'b0, 8'h58);
    send(1'b1, 1'b0, 8'h1C);
    settle();
    chk("caps_a", 32'(key_data), 32'h41);
    chk("caps_on", 32'(caps), 32'd1);
    check_state("caps");
    pop();
    send(1'b1, 1'b0, 8'h58);

    // Ctrl-C, Enter, unmapped extended
    send(1'b1, 1'b0, 8'h14);
    send(1'b1, 1'b0, 8'h21);
    settle();
    chk("ctrl_c", 32'(key_data), 32'h03);
    pop();
    send(1'b0, 1'b0, 8'h14);
    send(1'b1, 1'b0, 8'h5A);
    settle();
    chk("enter", 32'(key_data), 32'h0D);
    pop();
    send(1'b1, 1'b1, 8'h0E);
    settle();
    chk("unmapped.count", 32'(key_count), 32'd0);
    check_state("unmapped");

    // Overflow, then push coincident with pop on a full FIFO
    for (int i = 0; i < 9; i++) send(1'b1, 1'b0, fill_sc[i]);
    settle();
    chk("full.count", 32'(key_count), 32'd8);
    chk("full.ovf", 32'(overflow), 32'd1);
    check_state("full");
    tog = ~tog;
    ps2_key = {tog, 1'b1, 1'b0, 8'h4D};
    tick();
    tick();
    kb_rd = 1'b1;
    tick();
    kb_rd = 1'b0;
    void'(mq.pop_front());
    model_event(1'b1, 1'b0, 8'h4D);
    chk("pushpop.count", 32'(key_count), 32'd8);
    check_state("pushpop");
    for (int i = 0; i < 8; i++) begin
      pop();
      check_state("drain");
    end

    // kb_clr after overflow, and kb_clr colliding with a pending write
    for (int i = 0; i < 9; i++) send(1'b1, 1'b0, fill_sc[i]);
    settle();
    clear();
    chk("clr.count", 32'(key_count), 32'd0);
    chk("clr.ovf", 32'(overflow), 32'd0);
    send(1'b1, 1'b0, 8'h1C);
    tick();
    clear();
    tick();
    check_state("clr_pending");

`ifdef SMC777_KBD_IRQ_EN
    send(1'b1, 1'b0, 8'h32);
    tick();
    chk("irq_pre", 32'(kb_irq), 32'd0);
    tick();
    chk("irq_rise", 32'(kb_irq), 32'd1);
    pop();
    chk("irq_fall", 32'(kb_irq), 32'd0);
`endif

    // Toggle already high through reset release: no event
    reset = 1'b1;
    model_reset();
    tog = 1'b1;
    ps2_key = {tog, 1'b1, 1'b0, 8'h1C};
    tick();
    reset = 1'b0;
    tick();
    settle();
    tick();
    chk("tog_held.valid", 32'(key_valid), 32'd0);
    check_state("tog_held");

    // Reset between event and FIFO write
    send(1'b1, 1'b0, 8'h12);
    send(1'b1, 1'b0, 8'h1C);
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0;
    tick();
    settle();
    chk("rst_mid.valid", 32'(key_valid), 32'd0);
    check_state("rst_mid");

    // Randomized bursts against the reference model
    for (int it = 0; it < 150; it++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) rand_event();
      settle();
      check_state("rnd");
      if ($urandom_range(0, 9) == 0) begin
        clear();
        check_state("rnd_clr");
      end else begin
        repeat ($urandom_range(0, 3)) begin
          pop();
          check_state("rnd_pop");
        end
      end
    end

    do_reset();
    check_state("final_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/smc777_keyboard.md
# smc777_keyboard

Converts the MiSTer `ps2_key` event word into SMC-777 ASCII key codes, tracks modifier state and buffers codes in a small FIFO for the CPU keyboard port. Sits between `hps_io` (producer of `ps2_key`) and the `smc777` core's I/O decoder (consumer via read strobe).

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `clk` in 1: system clock (`clk_sys`).
- `reset` in 1: asynchronous, active-high reset.
- `ps2_key` in 11: [10] toggle per event, [9] 1=make/0=break, [8] extended (E0), [7:0] set-2 scancode.
- `kb_rd` in 1: one-cycle pop strobe from the CPU port read.
- `kb_clr` in 1: one-cycle strobe; flushes the FIFO and clears `overflow`.
- `key_data` out 8: FIFO head (first-word-fall-through); 0x00 when empty.
- `key_valid` out 1: FIFO non-empty.
- `key_count` out $clog2(DEPTH)+1: occupancy.
- `overflow` out 1: sticky; set when a code is dropped because the FIFO is full.
- `shift`, `ctrl`, `caps` out 1 each: current modifier state.
- `kb_irq` out 1: see Configuration.

## Operation
- Reset values: all outputs 0; FIFO empty; `armed` = 0.
- Arming: the first clock after reset deassertion sets `armed` = 1 and loads `prev_tog` = `ps2_key[10]`, with no event. This prevents a spurious event when the toggle is already 1.
- Event: when `armed` and `ps2_key[10]` != `prev_tog`, it is a 1-cycle `evt` pulse; `prev_tog` updates.
- Modifiers are consumed by state and never enter the FIFO:
  - Shift is 0x12 or 0x59, non-extended; left and right are tracked separately, and `shift` is their OR.
  - Ctrl is 0x14, extended or not; L and R are ORed.
  - Caps lock is a 0x58 make, which toggles `caps`; the break is ignored.
- Break codes of non-modifiers are ignored.
- Non-modifier make: stage 1 looks up {extended, shift, scancode} in the keymap, giving the base code or 0x00 if unmapped. Stage 2 applies the transforms below and then pushes the result if it is non-zero.
  - Caps: when `caps`=1 and the code is in 0x41..0x5A or 0x61..0x7A, bit 5 is inverted.
  - Ctrl: when `ctrl`=1 and the code is in 0x40..0x7F, the result is code & 0x1F. Ctrl takes precedence over caps.
- Push rules:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the code is dropped and `overflow` is set.
- Pop: `kb_rd` with `key_valid`=1 advances the head. `kb_rd` while empty is ignored.
- `kb_clr` has priority over both push and pop in the same cycle. The pending stage-2 code is discarded.
- Typematic repeat makes from the host are treated as new makes and pushed.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `key_count` is a separate counter: +1 on push-only, −1 on pop-only, unchanged on push+pop.

## Timing
- Toggle change sampled at edge N: `evt` at N, lookup registered at N+1, FIFO write at N+2. `key_valid`/`key_data` update after edge N+2 (2-cycle latency).
- Modifier make/break: `shift`/`ctrl`/`caps` update after edge N+1. A key event in the very next cycle sees the new state.
- Pop at edge M: the new head appears on `key_data` after edge M.
- Back-to-back events are accepted every cycle; the pipeline holds no stalls.
- Reset asserted mid-operation clears all state immediately, including the pipeline, FIFO and modifiers, and re-arms as above.

## Configuration
- `SMC777_KBD_IRQ_EN` defined:
  - `kb_irq` is a registered level, set when the FIFO goes empty→non-empty.
  - It stays high until the FIFO is empty again or `kb_clr` is asserted.
  - It is 0 at reset.
- Not defined: `kb_irq` is tied to 0 and no IRQ logic is built.

## Structure
- Package `smc777_kbd_pkg`:
  - scancode constants (`SC_LSHIFT`=0x12, `SC_RSHIFT`=0x59, `SC_CTRL`=0x14, `SC_CAPS`=0x58, `SC_ENTER`=0x5A);
  - a `key_evt_t` struct {tog, make, ext, code}.
- Sub-module `smc777_keymap`: synchronous ROM, 10-bit address {ext, shift, code}, 8-bit data, one-cycle read latency. It holds the full unshifted and shifted tables.

## Test plan
- Reset, then toggle an 0x1C make → after 2 clocks `key_valid`=1, `key_data`=0x61. `kb_rd` → `key_valid`=0.
- 0x12 make, then 0x1C make → 0x41. 0x12 break, then 0x1C make → 0x61. 0x58 make, then 0x1C make → 0x41 and `caps`=1.
- 0x14 make, then 0x21 make → 0x03. 0x5A make → 0x0D. Unmapped 0x0E extended → nothing pushed.
- `DEPTH`=8, nine makes without reads → `key_count`=8, `overflow`=1, ninth dropped. `kb_rd` coincident with a tenth push → count stays 8 and the push is accepted. `kb_clr` → count 0, `overflow` 0.
- `ps2_key[10]`=1 held through reset release → no event. Reset asserted between evt and FIFO write → FIFO stays empty.
- With `SMC777_KBD_IRQ_EN`: one make → `kb_irq` rises with `key_valid`, and falls on the pop that empties the FIFO.
